// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU function codes,
// condition codes, data-processing opcodes, instruction classes and ALU B-operand selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_DP   = 4'd2,
    WB_DP     = 4'd3,
    EXEC_ADDR = 4'd4,
    MEM       = 4'd5,
    WB_LD     = 4'd6,
    BRANCH    = 4'd7
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_COMP = 3'b011;
  localparam logic [2:0] ALU_MVB  = 3'b100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM12 = 2'b01;
  localparam logic [1:0] SRCB_BR    = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_cond.sv
// Condition-code evaluator: decides whether an instruction executes given {N,Z,C,V}.
module cond_check
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // NV and the unsupported codes never execute
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: one registered-state FSM driving
// fetch, decode, data-processing, load/store and branch control strobes.
//
// state     | meaning
// FETCH     | read instruction; on ready latch IR and PC+4
// DECODE    | check condition, dispatch on class
// EXEC_DP   | data-processing ALU op, optional flag update
// WB_DP     | write ALU result to register file
// EXEC_ADDR | compute load/store address (base +/- imm12)
// MEM       | memory access, held until ready
// WB_LD     | write loaded data to register file
// BRANCH    | PC <= PC + (sext(imm24) << 2)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int COND_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [3:0]  nzcv,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        flags_write,
  output logic [2:0]  alu_func,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        undef,
  output logic [3:0]  state
);

  state_t     state_q, state_d;
  logic       cond_raw, cond_pass;
  logic [3:0] opcode;
  logic       is_load;
  logic       unused_instr;

  assign opcode       = instr[24:21];
  assign is_load      = instr[20];
  assign unused_instr = ^{instr[22], instr[19:0]};

  cond_check u_cond (
    .cond (instr[31:28]),
    .nzcv (nzcv),
    .pass (cond_raw)
  );

  assign cond_pass = (COND_EN != 0) ? cond_raw : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    flags_write = 1'b0;
    alu_func    = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    undef       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (!cond_pass) begin
          state_d = FETCH;
        end else begin
          case (instr[27:26])
            CLS_DP:  state_d = EXEC_DP;
            CLS_MEM: state_d = EXEC_ADDR;
            CLS_BR:  state_d = BRANCH;
            default: begin
              undef   = 1'b1;
              state_d = FETCH;
            end
          endcase
        end
      end
      EXEC_DP: begin
        state_d   = WB_DP;
        alu_src_b = instr[25] ? SRCB_IMM12 : SRCB_REG;
        flags_write = instr[20];
        case (opcode)
          OP_ADD: alu_func = ALU_ADD;
          OP_SUB: alu_func = ALU_SUB;
          OP_AND: alu_func = ALU_AND;
          OP_MOV: alu_func = ALU_MVB;
          OP_MVN: alu_func = ALU_COMP;
          OP_CMP: begin
            alu_func    = ALU_SUB;
            flags_write = 1'b1;
            state_d     = FETCH;
          end
          default: begin
            // unsupported opcode: no datapath side effects at all
            alu_src_b   = SRCB_REG;
            flags_write = 1'b0;
            undef       = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      WB_DP: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      EXEC_ADDR: begin
        alu_func  = instr[23] ? ALU_ADD : ALU_SUB;
        alu_src_b = SRCB_IMM12;
        state_d   = MEM;
      end
      MEM: begin
        mem_read  = is_load;
        mem_write = !is_load;
        if (mem_ready) state_d = is_load ? WB_LD : FETCH;
      end
      WB_LD: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_func  = ALU_ADD;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_BR;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // reset forces every strobe low without waiting for a clock edge
    if (rst) begin
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = 1'b0;
      flags_write = 1'b0;
      alu_func    = ALU_ADD;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      undef       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors against hand-derived values.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [3:0]  nzcv;
  logic        mem_ready;
  logic        ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, wb_sel, flags_write;
  logic [2:0]  alu_func;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        undef;
  logic [3:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .nzcv        (nzcv),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .flags_write (flags_write),
    .alu_func    (alu_func),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .undef       (undef),
    .state       (state)
  );

  always #5 clk = ~clk;

  // strobe byte order: ir_write pc_write pc_src mem_read mem_write reg_write wb_sel flags_write
  function automatic logic [18:0] mk(input logic [3:0] st, input logic [7:0] str,
                                     input logic [2:0] af, input logic sa,
                                     input logic [1:0] sb, input logic un);
    return {st, str, af, sa, sb, un};
  endfunction

  function automatic logic [18:0] snap();
    return {state, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write, wb_sel,
            flags_write, alu_func, alu_src_a, alu_src_b, undef};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // sets mem_ready for the current cycle, samples mid-cycle, advances to the next negedge
  task automatic cyc(input string tag, input logic rdy, input logic [18:0] exp);
    mem_ready = rdy;
    #1;
    chk(tag, {13'b0, snap()}, {13'b0, exp});
    @(negedge clk);
  endtask

  localparam logic [18:0] V_ZERO  = 19'b0;
  localparam logic [18:0] V_FRDY  = {4'd0, 8'b11010000, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [18:0] V_FWAIT = {4'd0, 8'b00010000, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [18:0] V_DEC   = {4'd1, 8'b00000000, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [18:0] V_WBDP  = {4'd3, 8'b00000100, 3'b000, 1'b0, 2'b00, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr = 32'h0; nzcv = 4'h0; mem_ready = 1'b0;
    #2;
    chk("reset_outputs", {13'b0, snap()}, {13'b0, V_ZERO});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // fetch wait then ADD S=1 I=0
    instr = 32'hE0912003;
    cyc("fetch_wait", 1'b0, V_FWAIT);
    cyc("add_fetch",  1'b1, V_FRDY);
    cyc("add_decode", 1'b1, V_DEC);
    cyc("add_exec",   1'b1, mk(4'd2, 8'b00000001, 3'b000, 1'b0, 2'b00, 1'b0));
    cyc("add_wb",     1'b1, V_WBDP);

    // CMP: no writeback, 3 cycles
    instr = 32'hE1500001;
    cyc("cmp_fetch",  1'b1, V_FRDY);
    cyc("cmp_decode", 1'b1, V_DEC);
    cyc("cmp_exec",   1'b1, mk(4'd2, 8'b00000001, 3'b001, 1'b0, 2'b00, 1'b0));

    // MOV immediate, S=0
    instr = 32'hE3A00005;
    cyc("mov_fetch",  1'b1, V_FRDY);
    cyc("mov_decode", 1'b1, V_DEC);
    cyc("mov_exec",   1'b1, mk(4'd2, 8'b00000000, 3'b100, 1'b0, 2'b01, 1'b0));
    cyc("mov_wb",     1'b1, V_WBDP);

    // LDR U=0, three wait cycles in MEM: 8 cycles total
    instr = 32'hE5100004;
    cyc("ldr_fetch",  1'b1, V_FRDY);
    cyc("ldr_decode", 1'b1, V_DEC);
    cyc("ldr_addr",   1'b1, mk(4'd4, 8'b00000000, 3'b001, 1'b0, 2'b01, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("ldr_mem_wait", 1'b0, mk(4'd5, 8'b00010000, 3'b000, 1'b0, 2'b00, 1'b0));
    cyc("ldr_mem_done", 1'b1, mk(4'd5, 8'b00010000, 3'b000, 1'b0, 2'b00, 1'b0));
    cyc("ldr_wb",       1'b1, mk(4'd6, 8'b00000110, 3'b000, 1'b0, 2'b00, 1'b0));

    // BEQ not taken (Z=0): decode returns straight to fetch
    instr = 32'h0A000010; nzcv = 4'b0000;
    cyc("beq_nt_fetch",  1'b1, V_FRDY);
    cyc("beq_nt_decode", 1'b1, V_DEC);

    // BEQ taken (Z=1)
    nzcv = 4'b0100;
    cyc("beq_t_fetch",  1'b1, V_FRDY);
    cyc("beq_t_decode", 1'b1, V_DEC);
    cyc("beq_t_branch", 1'b1, mk(4'd7, 8'b01100000, 3'b000, 1'b1, 2'b10, 1'b0));

    // NV condition never executes even though class is a branch
    instr = 32'hFA000010;
    cyc("nv_fetch",  1'b1, V_FRDY);
    cyc("nv_decode", 1'b1, V_DEC);

    // class 11: one-cycle undef
    instr = 32'hEC000000;
    cyc("und_fetch",  1'b1, V_FRDY);
    cyc("und_decode", 1'b1, mk(4'd1, 8'b00000000, 3'b000, 1'b0, 2'b00, 1'b1));

    // unsupported DP opcode (EOR)
    instr = 32'hE0200000;
    cyc("eor_fetch",  1'b1, V_FRDY);
    cyc("eor_decode", 1'b1, V_DEC);
    cyc("eor_exec",   1'b1, mk(4'd2, 8'b00000000, 3'b000, 1'b0, 2'b00, 1'b1));

    // STR U=1 with reset asserted during the MEM wait
    instr = 32'hE5800000;
    cyc("str_fetch",  1'b1, V_FRDY);
    cyc("str_decode", 1'b1, V_DEC);
    cyc("str_addr",   1'b1, mk(4'd4, 8'b00000000, 3'b000, 1'b0, 2'b01, 1'b0));
    mem_ready = 1'b0;
    #1;
    chk("str_mem_wait", {13'b0, snap()},
        {13'b0, mk(4'd5, 8'b00001000, 3'b000, 1'b0, 2'b00, 1'b0)});
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {13'b0, snap()}, {13'b0, V_ZERO});
    @(negedge clk);
    chk("rst_held_reg_write", {31'b0, reg_write}, 32'd0);
    chk("rst_held", {13'b0, snap()}, {13'b0, V_ZERO});
    rst = 1'b0;
    cyc("post_rst_fetch", 1'b1, V_FRDY);
    cyc("post_rst_decode", 1'b1, V_DEC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
